fetch_ctrl: RTL and testbench

Sequencing controller for the instruction-fetch stage. It owns the fetch stage's `clr`, `jmp_en`, `hold_en` and `jmp_addr` inputs and arbitrates between branch redirects from execute, stall requests from decode, start/halt commands, and post-reset boot. It squashes the wrong-path instructions already in the fetch pipeline after a redirect, and tags every fetch output word with a valid bit for decode. It sits between the fetch stage and the decode/execute stages, and keeps stall/flush performance counters.

---
 rtl/fetch_pkg.sv | 29 ++
 rtl/sat_counter.sv | 29 ++
 rtl/fetch_ctrl.sv | 137 +++++++++++++
 tb/tb_fetch_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types for the fetch sequencing controller: FSM state
//                enum, default squash depth and the word-address type used by
//                fetch, i_cache and fetch_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package fetch_pkg;

    // Fetch pipeline depth: address register plus cache output register.
    localparam int FLUSH_CYCLES_DEF = 2;

    // Word address / PC-relative word offset.
    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_STALL = 3'd2,
        S_FLUSH = 3'd3,
        S_HALT  = 3'd4
    } state_t;

endpackage : fetch_pkg

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that sticks at all-ones; cleared only by reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Count up on inc, hold once every bit is set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule : sat_counter

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// ============================================================================
//  Module      : fetch_ctrl
//  Description : Instruction-fetch sequencing controller. Arbitrates halt,
//                branch redirect, decode stall and start/boot; squashes the
//                wrong-path words still inside the fetch pipeline and tags
//                each fetch output word with a valid bit.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             halt_req,
    input  logic             br_taken,
    input  word_t            br_off,
    input  logic             stall_req,
    output logic             f_clr,
    output logic             f_jmp_en,
    output word_t            f_jmp_addr,
    output logic             f_hold_en,
    output logic             ins_valid,
    output logic             flush_de,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int             SQ_W    = $clog2(FLUSH_CYCLES + 1);
    localparam logic [SQ_W-1:0] SQ_LOAD = SQ_W'(FLUSH_CYCLES);
    localparam logic [SQ_W-1:0] SQ_ONE  = SQ_W'(1);

    state_t          state;
    state_t          state_nx;
    logic [SQ_W-1:0] squash;
    logic [SQ_W-1:0] squash_nx;

    // Next-state arbitration and the combinational fetch controls.
    // Priority inside the fetching states: halt > branch > stall.
    always_comb begin
        state_nx  = state;
        squash_nx = squash;
        f_clr     = 1'b0;
        f_jmp_en  = 1'b0;
        f_hold_en = 1'b0;
        flush_de  = 1'b0;
        case (state)
            S_IDLE: begin
                f_clr     = 1'b1;
                f_hold_en = 1'b1;
                if (start) begin
                    state_nx  = S_FLUSH;
                    squash_nx = SQ_LOAD;
                end
            end
            S_HALT: begin
                f_hold_en = 1'b1;
                // Restart clears fetch for exactly the cycle we leave HALT.
                if (start) begin
                    f_clr     = 1'b1;
                    state_nx  = S_FLUSH;
                    squash_nx = SQ_LOAD;
                end
            end
            S_RUN, S_STALL, S_FLUSH: begin
                if (halt_req) begin
                    flush_de  = 1'b1;
                    state_nx  = S_HALT;
                    squash_nx = '0;
                end else if (br_taken) begin
                    f_jmp_en  = 1'b1;
                    flush_de  = 1'b1;
                    state_nx  = S_FLUSH;
                    squash_nx = SQ_LOAD;
                end else if (state == S_FLUSH) begin
                    // Bubbles need no hold, so stall_req is ignored here.
                    squash_nx = squash - 1'b1;
                    if (squash <= SQ_ONE) begin
                        state_nx = S_RUN;
                    end
                end else if (stall_req) begin
                    f_hold_en = 1'b1;
                    state_nx  = S_STALL;
                end else begin
                    state_nx  = S_RUN;
                end
            end
            default: begin
                state_nx  = S_IDLE;
                squash_nx = '0;
            end
        endcase
    end

    // Jump address is forced to zero unless a jump is actually issued.
    assign f_jmp_addr = f_jmp_en ? br_off : '0;

    // State, squash counter and the registered state decodes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            squash    <= '0;
            ins_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            squash    <= squash_nx;
            ins_valid <= (state_nx == S_RUN) || (state_nx == S_STALL);
            busy      <= (state_nx == S_RUN) || (state_nx == S_STALL) ||
                         (state_nx == S_FLUSH);
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (state == S_STALL),
        .cnt   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (state == S_FLUSH),
        .cnt   (flush_cnt)
    );

endmodule : fetch_ctrl

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// ============================================================================
//  Module      : tb_fetch_ctrl
//  Description : Self-checking bench for fetch_ctrl. Directed boot, branch,
//                stall, branch-in-flush, halt/restart, saturation and async
//                reset steps, then randomized traffic, all compared against a
//                behavioural model of the fetch sequencing rules.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fetch_ctrl;
    import fetch_pkg::*;

    localparam int FC = 2;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        halt_req;
    logic        br_taken;
    word_t       br_off;
    logic        stall_req;

    logic        f_clr, f_jmp_en, f_hold_en, ins_valid, flush_de, busy;
    word_t       f_jmp_addr;
    logic [31:0] stall_cnt, flush_cnt;

    logic        f_clr4, f_jmp_en4, f_hold_en4, ins_valid4, flush_de4, busy4;
    word_t       f_jmp_addr4;
    logic [3:0]  stall_cnt4, flush_cnt4;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: is the core fetching, how many squash bubbles remain,
    // was the last fetch cycle a held one, and did we stop via halt.
    bit     m_on;
    bit     m_halted;
    bit     m_stalled;
    int     m_squash;
    longint m_scnt;
    longint m_fcnt;

    fetch_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
        .br_taken(br_taken), .br_off(br_off), .stall_req(stall_req),
        .f_clr(f_clr), .f_jmp_en(f_jmp_en), .f_jmp_addr(f_jmp_addr),
        .f_hold_en(f_hold_en), .ins_valid(ins_valid), .flush_de(flush_de),
        .busy(busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    fetch_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
        .br_taken(br_taken), .br_off(br_off), .stall_req(stall_req),
        .f_clr(f_clr4), .f_jmp_en(f_jmp_en4), .f_jmp_addr(f_jmp_addr4),
        .f_hold_en(f_hold_en4), .ins_valid(ins_valid4), .flush_de(flush_de4),
        .busy(busy4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic longint sat(input longint v, input longint maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic model_reset();
        m_on      = 1'b0;
        m_halted  = 1'b0;
        m_stalled = 1'b0;
        m_squash  = 0;
        m_scnt    = 0;
        m_fcnt    = 0;
    endtask

    task automatic check_reset_values();
        chk("rst_f_clr",      64'(f_clr),      64'd1);
        chk("rst_f_jmp_en",   64'(f_jmp_en),   64'd0);
        chk("rst_f_jmp_addr", 64'(f_jmp_addr), 64'd0);
        chk("rst_f_hold_en",  64'(f_hold_en),  64'd1);
        chk("rst_ins_valid",  64'(ins_valid),  64'd0);
        chk("rst_flush_de",   64'(flush_de),   64'd0);
        chk("rst_busy",       64'(busy),       64'd0);
        chk("rst_stall_cnt",  64'(stall_cnt),  64'd0);
        chk("rst_flush_cnt",  64'(flush_cnt),  64'd0);
        chk("rst_stall_cnt4", 64'(stall_cnt4), 64'd0);
        chk("rst_flush_cnt4", 64'(flush_cnt4), 64'd0);
    endtask

    // One clock: compare outputs mid-cycle, then advance the model on the edge.
    task automatic step();
        logic  e_clr, e_jmp, e_hold, e_fde, e_valid, e_busy;
        word_t e_addr;
        @(negedge clk);
        e_clr   = 1'b0;
        e_jmp   = 1'b0;
        e_addr  = '0;
        e_hold  = 1'b0;
        e_fde   = 1'b0;
        e_valid = m_on && (m_squash == 0);
        e_busy  = m_on;
        if (!m_on) begin
            e_clr  = !m_halted || start;
            e_hold = 1'b1;
        end else if (halt_req) begin
            e_fde = 1'b1;
        end else if (br_taken) begin
            e_jmp  = 1'b1;
            e_addr = br_off;
            e_fde  = 1'b1;
        end else if (m_squash == 0) begin
            e_hold = stall_req;
        end
        chk("f_clr",      64'(f_clr),      64'(e_clr));
        chk("f_jmp_en",   64'(f_jmp_en),   64'(e_jmp));
        chk("f_jmp_addr", 64'(f_jmp_addr), 64'(e_addr));
        chk("f_hold_en",  64'(f_hold_en),  64'(e_hold));
        chk("ins_valid",  64'(ins_valid),  64'(e_valid));
        chk("flush_de",   64'(flush_de),   64'(e_fde));
        chk("busy",       64'(busy),       64'(e_busy));
        chk("stall_cnt",  64'(stall_cnt),  64'(sat(m_scnt, 64'hFFFF_FFFF)));
        chk("flush_cnt",  64'(flush_cnt),  64'(sat(m_fcnt, 64'hFFFF_FFFF)));
        chk("stall_cnt4", 64'(stall_cnt4), 64'(sat(m_scnt, 15)));
        chk("flush_cnt4", 64'(flush_cnt4), 64'(sat(m_fcnt, 15)));
        @(posedge clk);
        if (m_on && m_squash == 0 && m_stalled) m_scnt++;
        if (m_on && m_squash > 0)               m_fcnt++;
        if (!m_on) begin
            if (start) begin
                m_on      = 1'b1;
                m_squash  = FC;
                m_stalled = 1'b0;
            end
        end else if (halt_req) begin
            m_on      = 1'b0;
            m_halted  = 1'b1;
            m_squash  = 0;
            m_stalled = 1'b0;
        end else if (br_taken) begin
            m_squash  = FC;
            m_stalled = 1'b0;
        end else if (m_squash > 0) begin
            m_squash--;
        end else begin
            m_stalled = stall_req;
        end
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        halt_req  = 1'b0;
        br_taken  = 1'b0;
        br_off    = '0;
        stall_req = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_values();
        rst_n = 1'b1;

        // Boot: idle a few cycles, start pulse, two bubbles, then valid words.
        steps(4);
        start = 1'b1; step(); start = 1'b0;
        steps(3);
        chk("boot_flush_cnt", 64'(flush_cnt), 64'd2);

        // Branch from RUN to offset 0x10.
        steps(2);
        br_taken = 1'b1; br_off = 32'h10; step(); br_taken = 1'b0;
        steps(3);

        // Three-cycle stall, then release with no bubble.
        stall_req = 1'b1; steps(3); stall_req = 1'b0;
        steps(2);
        chk("stall3_cnt", 64'(stall_cnt), 64'd3);

        // Second branch one cycle into FLUSH, with a stall asserted alongside.
        br_taken = 1'b1; br_off = 32'h20; stall_req = 1'b1; step();
        br_off = 32'h30; step();
        br_taken = 1'b0; stall_req = 1'b0;
        steps(4);

        // Halt together with branch, sit in HALT, then restart.
        halt_req = 1'b1; br_taken = 1'b1; br_off = 32'h40; step();
        halt_req = 1'b0; br_taken = 1'b0; stall_req = 1'b1;
        steps(2);
        stall_req = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        steps(4);

        // Long stall drives the 4-bit counter into saturation.
        stall_req = 1'b1; steps(20); stall_req = 1'b0;
        step();
        chk("sat_stall_cnt4", 64'(stall_cnt4), 64'd15);

        // Async reset in the middle of a FLUSH with a redirect pending.
        br_taken = 1'b1; br_off = 32'h50; step();
        br_off = 32'h44;
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_values();
        br_taken = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        steps(2);
        start = 1'b1; step(); start = 1'b0;
        steps(3);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            start     = ($urandom_range(0, 9)  == 0);
            halt_req  = ($urandom_range(0, 29) == 0);
            br_taken  = ($urandom_range(0, 7)  == 0);
            stall_req = ($urandom_range(0, 2)  == 0);
            br_off    = $urandom;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_fetch_ctrl

`default_nettype wire
